// File: rtl/teletext_pixel_serializer.sv
// Teletext pixel serializer: buffers 6-pixel RGB groups in a small FIFO and emits one {r,g,b} pixel per beat.
// Optional status counters (ovf_count, max_level) are built only when TELETEXT_PIXEL_SERIALIZER_STATUS_EN is defined.
module teletext_pixel_serializer #(
    parameter int DEPTH_LOG2  = 3,
    parameter int LINE_PIXELS = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_sol,
    input  logic                  in_sof,
    input  logic [5:0]            in_red,
    input  logic [5:0]            in_green,
    input  logic [5:0]            in_blue,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_pixel,
    output logic                  out_sol,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [9:0]            out_x,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            ovf_count,
    output logic [DEPTH_LOG2:0]   max_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [9:0] X_LAST = 10'(LINE_PIXELS - 1);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Group word layout: [19]=sof, [18]=sol, [17:12]=red, [11:6]=green, [5:0]=blue
    logic [19:0]           fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic [0:0]            state_reg;
    logic [2:0]            index_reg;
    logic [19:0]           group_reg;
    logic [9:0]            x_reg;
    logic                  overflow_reg;

    logic        full;
    logic        beat;
    logic        last_pixel;
    logic        push;
    logic        pop;
    logic        drop;
    logic [19:0] head;
    logic [2:0]  bit_sel;
    logic [2:0]  pixel_bits;

    assign head       = fifo_mem[rd_ptr_reg];
    assign full       = (level_reg == FULL_LEVEL);
    assign beat       = (state_reg == ST_SHIFT) && out_ready;
    assign last_pixel = (index_reg == 3'd5);
    // Fullness uses the registered level, so a same-cycle pop never rescues a push into a full FIFO.
    assign push       = !flush && in_valid && !full;
    assign drop       = !flush && in_valid && full;
    assign pop        = !flush && (level_reg != '0) &&
                        ((state_reg == ST_IDLE) || (beat && last_pixel));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {in_sof, in_sol, in_red, in_green, in_blue};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            state_reg    <= ST_IDLE;
            index_reg    <= '0;
            group_reg    <= '0;
            x_reg        <= '0;
            overflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            state_reg    <= ST_IDLE;
            index_reg    <= '0;
            group_reg    <= '0;
            x_reg        <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (drop) begin
                overflow_reg <= 1'b1;
            end

            if (pop) begin
                group_reg <= head;
                index_reg <= '0;
                state_reg <= ST_SHIFT;
            end else if (beat) begin
                if (last_pixel) begin
                    index_reg <= '0;
                    state_reg <= ST_IDLE;
                end else begin
                    index_reg <= index_reg + 3'd1;
                end
            end

            // x_reg always holds the position of the pixel presented next; a sol group restarts it.
            if (pop && head[18]) begin
                x_reg <= '0;
            end else if (beat) begin
                x_reg <= (x_reg == X_LAST) ? x_reg : x_reg + 10'd1;
            end
        end
    end

    assign bit_sel = 3'd5 - index_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_plane
        logic [5:0] plane;
        assign plane          = group_reg[6*gi +: 6];
        assign pixel_bits[gi] = plane[bit_sel];
    end

    assign out_valid = (state_reg == ST_SHIFT);
    assign out_pixel = out_valid ? pixel_bits : 3'b000;
    assign out_sol   = out_valid && (index_reg == 3'd0) && group_reg[18];
    assign out_sof   = out_valid && (index_reg == 3'd0) && group_reg[19];
    assign out_eol   = out_valid && (x_reg == X_LAST);
    assign out_x     = x_reg;
    assign overflow  = overflow_reg;
    assign level     = level_reg;

`ifdef TELETEXT_PIXEL_SERIALIZER_STATUS_EN
    logic [7:0]          ovf_count_reg;
    logic [DEPTH_LOG2:0] max_level_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count_reg <= '0;
            max_level_reg <= '0;
        end else if (flush) begin
            ovf_count_reg <= '0;
            max_level_reg <= '0;
        end else begin
            if (drop && (ovf_count_reg != 8'hFF)) begin
                ovf_count_reg <= ovf_count_reg + 8'd1;
            end
            if (level_reg > max_level_reg) begin
                max_level_reg <= level_reg;
            end
        end
    end

    assign ovf_count = ovf_count_reg;
    assign max_level = max_level_reg;
`else
    assign ovf_count = '0;
    assign max_level = '0;
`endif

endmodule

// File: tb/tb_teletext_pixel_serializer.sv
// Scoreboard bench for teletext_pixel_serializer: stimulus queues expected pixels, a monitor checks every beat.
// Expectations for the status outputs follow TELETEXT_PIXEL_SERIALIZER_STATUS_EN.
module tb_teletext_pixel_serializer;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_sol, in_sof, out_ready;
    logic [5:0] in_red, in_green, in_blue;
    logic       out_valid, out_sol, out_sof, out_eol, overflow;
    logic [2:0] out_pixel;
    logic [9:0] out_x;
    logic [3:0] level, max_level;
    logic [7:0] ovf_count;

    teletext_pixel_serializer #(.DEPTH_LOG2(3), .LINE_PIXELS(480)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_sol(in_sol), .in_sof(in_sof),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sol(out_sol), .out_sof(out_sof), .out_eol(out_eol), .out_x(out_x),
        .overflow(overflow), .level(level), .ovf_count(ovf_count), .max_level(max_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] pix;
        logic       sol;
        logic       sof;
        logic [9:0] x;
        bit         chk_x;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    bit   cnt_en = 1'b0;
    int   valid_cycles = 0;
    int   valid_rises = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_pixel: got pixel %0d x %0d, expected no pixel", out_pixel, out_x);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk_x)
                    check("pixel_x", {16'd0, out_eol, out_x, out_pixel, out_sol, out_sof},
                          {16'd0, (mon_e.x == 10'd479), mon_e.x, mon_e.pix, mon_e.sol, mon_e.sof});
                else
                    check("pixel", {27'd0, out_pixel, out_sol, out_sof},
                          {27'd0, mon_e.pix, mon_e.sol, mon_e.sof});
            end
        end
    end

    always @(negedge clk) begin
        if (cnt_en) begin
            if (out_valid) valid_cycles++;
            if (out_valid && !prev_v) valid_rises++;
            prev_v = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_group(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                              input logic sol, input logic sof, input bit expect_out,
                              input bit chk_x, input int x0);
        exp_t e;
        if (expect_out) begin
            for (int i = 0; i < 6; i++) begin
                e.pix   = {r[5-i], g[5-i], b[5-i]};
                e.sol   = sol && (i == 0);
                e.sof   = sof && (i == 0);
                e.x     = (x0 + i > 479) ? 10'd479 : 10'(x0 + i);
                e.chk_x = chk_x;
                sb.push_back(e);
            end
        end
        in_valid = 1'b1; in_red = r; in_green = g; in_blue = b; in_sol = sol; in_sof = sof;
        tick();
        in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_level", {28'd0, level}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_x", {22'd0, out_x}, 32'd0);
        check("reset_pixel_tags", {27'd0, out_pixel, out_sol, out_sof}, 32'd0);
        check("reset_status", {20'd0, ovf_count, max_level}, 32'd0);

        // Single group: pixels 5,1,5,1,5,1; out_valid rises one edge after the push edge.
        out_ready = 1'b1;
        push_group(6'b101010, 6'b000000, 6'b111111, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("t1_valid_at_push", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_valid_after_pop", {31'd0, out_valid}, 32'd1);
        check("t1_first_pixel", {29'd0, out_pixel}, 32'd5);
        wait_drain("t1_drain", 20);

        // Stalled: first group moves into the serializer, nine fill level to 8, the tenth is dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++)
            push_group(6'(k + 1), 6'(k * 7), ~6'(k), 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check("t2_level_full", {28'd0, level}, 32'd8);
        check("t2_no_overflow_yet", {31'd0, overflow}, 32'd0);
        push_group(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("t2_overflow", {31'd0, overflow}, 32'd1);
        check("t2_level_after_drop", {28'd0, level}, 32'd8);
        out_ready = 1'b1;
        wait_drain("t2_drain", 120);

        // One group every 6 cycles: valid must stay high for all 30 pixels with no bubble.
        valid_cycles = 0; valid_rises = 0; prev_v = 1'b0; cnt_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_group(6'(k * 11 + 3), 6'(k * 5 + 1), 6'(42 - k), 1'b0, 1'b0, 1'b1, 1'b0, 0);
            repeat (5) tick();
        end
        wait_drain("t3_drain", 40);
        cnt_en = 1'b0;
        check("t3_valid_cycles", valid_cycles, 32'd30);
        check("t3_valid_rises", valid_rises, 32'd1);

        // Full line of 80 groups, one saturating group, then a sol group restarting x.
        for (int k = 0; k < 82; k++) begin
            push_group(6'(k), 6'(k * 3), 6'(k * 5), (k == 0 || k == 81), (k == 0),
                       1'b1, 1'b1, (k == 81) ? 0 : k * 6);
            repeat (5) tick();
        end
        wait_drain("t4_drain", 40);

        // Flush mid-group with a same-cycle push: everything, including that push, disappears.
        check("t5_overflow_before", {31'd0, overflow}, 32'd1);
        push_group(6'b110011, 6'b001100, 6'b101101, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        push_group(6'b011110, 6'b100001, 6'b010010, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick();
        tick();
        flush = 1'b1;
        in_valid = 1'b1; in_red = 6'h15; in_green = 6'h2A; in_blue = 6'h3F;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_level", {28'd0, level}, 32'd0);
        check("t5_overflow", {31'd0, overflow}, 32'd0);
        check("t5_x", {22'd0, out_x}, 32'd0);
        repeat (10) tick();
        check("t5_no_reappear", {27'd0, out_valid, level}, 32'd0);

        // 300 drops on top of a full FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 309; k++)
            push_group(6'(k), 6'(k + 1), 6'(k + 2), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick();
        check("t6_level", {28'd0, level}, 32'd8);
        check("t6_overflow", {31'd0, overflow}, 32'd1);
`ifdef TELETEXT_PIXEL_SERIALIZER_STATUS_EN
        check("t6_ovf_count", {24'd0, ovf_count}, 32'd255);
        check("t6_max_level", {28'd0, max_level}, 32'd8);
`else
        check("t6_ovf_count", {24'd0, ovf_count}, 32'd0);
        check("t6_max_level", {28'd0, max_level}, 32'd0);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_status", {20'd0, ovf_count, max_level}, 32'd0);
        check("t6_flush_level", {28'd0, level}, 32'd0);

        // Asynchronous reset mid-group takes effect without a clock edge.
        push_group(6'h3C, 6'h0F, 6'h33, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();
        check("t7_valid_before_reset", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("t7_async_reset", {27'd0, out_valid, level}, 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("t7_after_reset", {27'd0, out_valid, level}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
